// File: rtl/clint_timer_unit.sv
// CLINT register block: msip, mtimecmp and free-running mtime with a prescaler,
// behind a single-outstanding request/response port.
//
// state  | meaning
// S_IDLE | ready for a request; access is performed on acceptance
// S_RESP | response held on resp_* until resp_ready_i
module clint_timer_unit #(
  parameter int          XLEN      = 64,
  parameter int          TICK_DIV  = 1,
  parameter logic [15:0] BASE_MASK = 16'hFFFF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [15:0]       req_addr_i,
  input  logic [XLEN-1:0]   req_wdata_i,
  input  logic [XLEN/8-1:0] req_wstrb_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [XLEN-1:0]   resp_rdata_o,
  output logic              resp_err_o,
  output logic              msi_o,
  output logic              mti_o,
  output logic [XLEN-1:0]   mtime_o
);

  localparam int SW = XLEN / 8;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic {S_IDLE, S_RESP} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] mtime_q, mtime_d;
  logic [XLEN-1:0] cmp_q, cmp_d;
  logic            msip_q, msip_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            mti_q, mti_d;

  logic [15:0]     off;
  logic            sel_msip, sel_cmp, sel_mtime, hit, tick;
  logic [XLEN-1:0] rd_val;

  function automatic logic [XLEN-1:0] merge(input logic [XLEN-1:0] old_v,
                                            input logic [XLEN-1:0] new_v,
                                            input logic [SW-1:0]   strb);
    logic [XLEN-1:0] r;
    r = old_v;
    for (int i = 0; i < SW; i++) begin
      if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  // Low three offset bits are don't-care: every register is 8-byte aligned.
  assign off       = req_addr_i & BASE_MASK;
  assign sel_msip  = (off & 16'hFFF8) == 16'h0000;
  assign sel_cmp   = (off & 16'hFFF8) == 16'h4000;
  assign sel_mtime = (off & 16'hFFF8) == 16'hBFF8;
  assign hit       = sel_msip | sel_cmp | sel_mtime;
  assign tick      = (presc_q == PW'(TICK_DIV - 1));

  always_comb begin
    rd_val = '0;
    if (sel_msip)  rd_val = {{(XLEN-1){1'b0}}, msip_q};
    if (sel_cmp)   rd_val = cmp_q;
    if (sel_mtime) rd_val = mtime_q;
  end

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    msip_d  = msip_q;
    cmp_d   = cmp_q;
    presc_d = tick ? '0 : presc_q + PW'(1);
    mtime_d = tick ? mtime_q + XLEN'(1) : mtime_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          state_d = S_RESP;
          err_d   = ~hit;
          rdata_d = req_write_i ? '0 : rd_val;
          if (req_write_i) begin
            if (sel_msip && req_wstrb_i[0]) msip_d = req_wdata_i[0];
            if (sel_cmp)   cmp_d   = merge(cmp_q, req_wdata_i, req_wstrb_i);
            // A bus write to mtime overrides this cycle's increment; prescaler keeps running.
            if (sel_mtime) mtime_d = merge(mtime_q, req_wdata_i, req_wstrb_i);
          end
        end
      end
      S_RESP: begin
        if (resp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    mti_d = (mtime_d >= cmp_d);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      mtime_q <= '0;
      cmp_q   <= '1;
      msip_q  <= 1'b0;
      presc_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      mti_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mtime_q <= mtime_d;
      cmp_q   <= cmp_d;
      msip_q  <= msip_d;
      presc_q <= presc_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      mti_q   <= mti_d;
    end
  end

  assign req_ready_o  = (state_q == S_IDLE);
  assign resp_valid_o = (state_q == S_RESP);
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;
  assign msi_o        = msip_q;
  assign mti_o        = mti_q;
  assign mtime_o      = mtime_q;

endmodule

// File: tb/tb_clint_timer_unit.sv
// Directed bench for clint_timer_unit with TICK_DIV=1; inputs driven and
// outputs sampled on the falling edge.
module tb_clint_timer_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [15:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic        resp_valid, resp_ready, resp_err;
  logic [63:0] resp_rdata;
  logic        msi, mti;
  logic [63:0] mtime;

  logic [63:0] rd;
  logic        er;
  logic        found;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  clint_timer_unit dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
    .msi_o(msi), .mti_o(mti), .mtime_o(mtime)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // One transaction with resp_ready held high; returns at the falling edge
  // after acceptance, when the response is visible.
  task automatic bus(input logic wr, input logic [15:0] addr, input logic [63:0] wd,
                     input logic [7:0] ws, output logic [63:0] rdata, output logic err);
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_wstrb = ws;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("resp_valid", resp_valid, 1'b1);
    rdata = resp_rdata;
    err   = resp_err;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_wstrb = '0; resp_ready = 1'b1;
    #3;
    check("rst_mtime", mtime, 64'd0);
    check("rst_mti", mti, 1'b0);
    check("rst_msi", msi, 1'b0);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_rdata", resp_rdata, 64'd0);
    check("rst_err", resp_err, 1'b0);

    @(negedge clk); rst_n = 1'b1;
    check("count0", mtime, 64'd0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check("count", mtime, 64'(i));
      check("count_mti", mti, 1'b0);
    end

    // msip set / read / clear, plus an all-zero strobe no-op
    bus(1'b1, 16'h0000, 64'h1, 8'hFF, rd, er);
    check("msip_wr_err", er, 1'b0);
    check("msip_wr_rdata", rd, 64'd0);
    check("msi_set", msi, 1'b1);
    bus(1'b0, 16'h0000, 64'h0, 8'h00, rd, er);
    check("msip_rd", rd, 64'h1);
    bus(1'b1, 16'h0000, 64'h0, 8'hFF, rd, er);
    check("msi_clr", msi, 1'b0);
    bus(1'b1, 16'h0000, 64'h1, 8'h00, rd, er);
    check("zero_strb_err", er, 1'b0);
    check("zero_strb_msi", msi, 1'b0);

    // mtime write then read: read returns the pre-update value two cycles later
    bus(1'b1, 16'hBFF8, 64'd100, 8'hFF, rd, er);
    check("mtime_wr", mtime, 64'd100);
    bus(1'b0, 16'hBFF8, 64'd0, 8'h00, rd, er);
    check("mtime_rd", rd, 64'd101);

    // compare crossing at 20
    bus(1'b1, 16'hBFF8, 64'd5, 8'hFF, rd, er);
    bus(1'b1, 16'h4000, 64'd20, 8'hFF, rd, er);
    check("mti_before", mti, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (mtime == 64'd19) begin found = 1'b1; break; end
      @(negedge clk);
    end
    check("reach19", found, 1'b1);
    check("mti_at19", mti, 1'b0);
    @(negedge clk);
    check("mtime20", mtime, 64'd20);
    check("mti_at20", mti, 1'b1);
    bus(1'b1, 16'h4000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, rd, er);
    check("mti_drop", mti, 1'b0);

    // write on a tick cycle and wrap with mtimecmp=0
    bus(1'b1, 16'h4000, 64'd0, 8'hFF, rd, er);
    check("mti_cmp0", mti, 1'b1);
    bus(1'b1, 16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, rd, er);
    check("wrap_fe", mtime, 64'hFFFF_FFFF_FFFF_FFFE);
    check("wrap_mti_fe", mti, 1'b1);
    @(negedge clk);
    check("wrap_ff", mtime, 64'hFFFF_FFFF_FFFF_FFFF);
    check("wrap_mti_ff", mti, 1'b1);
    @(negedge clk);
    check("wrap_0", mtime, 64'd0);
    check("wrap_mti_0", mti, 1'b1);

    // partial mtimecmp write after a fresh reset
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    bus(1'b1, 16'h4000, 64'h0000_0000_AABB_CCDD, 8'h0F, rd, er);
    bus(1'b0, 16'h4000, 64'd0, 8'h00, rd, er);
    check("partial_rd", rd, 64'hFFFF_FFFF_AABB_CCDD);
    check("partial_err", er, 1'b0);

    // unmapped offsets
    bus(1'b0, 16'h0100, 64'd0, 8'h00, rd, er);
    check("unmap_rd_data", rd, 64'd0);
    check("unmap_rd_err", er, 1'b1);
    bus(1'b1, 16'h0100, 64'h1234, 8'hFF, rd, er);
    check("unmap_wr_err", er, 1'b1);

    // backpressure, then asynchronous reset during the hold
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h4000; req_wstrb = 8'h00;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", resp_valid, 1'b1);
      check("bp_rdata", resp_rdata, 64'hFFFF_FFFF_AABB_CCDD);
      check("bp_req_ready", req_ready, 1'b0);
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", resp_valid, 1'b0);
    check("arst_req_ready", req_ready, 1'b1);
    check("arst_mtime", mtime, 64'd0);
    check("arst_rdata", resp_rdata, 64'd0);
    resp_ready = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
